fsm_pulse_tx: RTL and testbench

//  Transmit end of the serial "count-ones" link: turns a burst request into a serial

---
 rtl/fsm_pkg.sv | 19 +
 rtl/pulse_gap_timer.sv | 36 +++
 rtl/fsm_pulse_tx.sv | 123 ++++++++++++
 tb/tb_fsm_pulse_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the count-ones pulse transmitter: state encoding,
// default group length and a width helper for the in-group pulse index.
package fsm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int DEFAULT_GROUP_LEN = 4;

    // A group length of 1 still needs a 1-bit index so the wrap compare stays legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_gap_timer.sv
// Loadable down-counter that times the zero gap between consecutive ones.
// expire is high on the final cycle of the loaded gap.
module pulse_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [GAP_W-1:0] cnt_q;
    logic [GAP_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q <= GAP_W'(1));

endmodule

// File: rtl/fsm_pulse_tx.sv
// Transmit end of the count-ones link: expands a burst request into groups of
// GROUP_LEN single-cycle ones separated by programmable zero gaps.
module fsm_pulse_tx
    import fsm_pkg::*;
#(
    parameter int GROUP_LEN = DEFAULT_GROUP_LEN,
    parameter int CNT_W     = 8,
    parameter int GAP_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_groups,
    input  logic [GAP_W-1:0] req_gap,
    output logic             data,
    output logic             grp_end,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = idx_width(GROUP_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] grp_q, grp_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             data_q, data_d;
    logic             grp_end_q, grp_end_d;
    logic             done_q, done_d;
    logic             timer_load;
    logic             gap_expire;
    logic             group_last;

    assign group_last = (idx_q == LAST_IDX);

    pulse_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (gap_q),
        .en       (state_q == S_GAP),
        .expire   (gap_expire)
    );

    // idx tracks the in-group index of the pulse currently (or next) on the line,
    // so grp_end can be registered alongside data from the same next-state view.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        grp_d      = grp_q;
        gap_d      = gap_q;
        timer_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    grp_d   = req_groups;
                    gap_d   = req_gap;
                    idx_d   = '0;
                    state_d = (req_groups != '0) ? S_ONE : S_DONE;
                end
            end
            S_ONE: begin
                idx_d = group_last ? '0 : idx_q + 1'b1;
                if (group_last) begin
                    grp_d = grp_q - 1'b1;
                end
                if (group_last && (grp_q == CNT_W'(1))) begin
                    state_d = S_DONE;
                end else if (gap_q != '0) begin
                    state_d    = S_GAP;
                    timer_load = 1'b1;
                end else begin
                    state_d = S_ONE;
                end
            end
            S_GAP: begin
                if (gap_expire) begin
                    state_d = S_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        data_d    = (state_d == S_ONE);
        grp_end_d = (state_d == S_ONE) && (idx_d == LAST_IDX);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            grp_q     <= '0;
            gap_q     <= '0;
            data_q    <= 1'b0;
            grp_end_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            grp_q     <= grp_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            grp_end_q <= grp_end_d;
            done_q    <= done_d;
        end
    end

    assign data      = data_q;
    assign grp_end   = grp_end_q;
    assign done      = done_q;
    assign busy      = (state_q == S_ONE) || (state_q == S_GAP);
    assign req_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_fsm_pulse_tx.sv
// Testbench for fsm_pulse_tx: table vectors, randomized bursts and hand-written
// corner sequences, all compared against a waveform model built from the burst rules.
module tb_fsm_pulse_tx;

    localparam int GL    = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_groups;
    logic [GAP_W-1:0] req_gap;
    logic             data;
    logic             grp_end;
    logic             busy;
    logic             done;

    int total_checks  = 0;
    int passed_checks = 0;

    // Expected per-cycle outputs packed as {req_ready, data, grp_end, busy, done}.
    logic [4:0] exp_q[$];

    int obs_ones, obs_len, obs_ends, obs_flags, flag_align_errs;

    logic [$clog2(GL)-1:0] det_cnt;
    logic                  det_flag;

    typedef struct {
        int groups;
        int gap;
        int exp_ones;
        int exp_len;
        int exp_ends;
    } vec_t;

    vec_t vecs[6];

    fsm_pulse_tx #(
        .GROUP_LEN (GL),
        .CNT_W     (CNT_W),
        .GAP_W     (GAP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_groups (req_groups),
        .req_gap    (req_gap),
        .data       (data),
        .grp_end    (grp_end),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Downstream mod-GL ones-counting detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_cnt  <= '0;
            det_flag <= 1'b0;
        end else begin
            det_flag <= data && (det_cnt == GL - 1);
            if (data) begin
                det_cnt <= (det_cnt == GL - 1) ? '0 : det_cnt + 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic build_model(input int groups, input int gap);
        int n;
        n = GL * groups;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, 1'b1, (i % GL) == GL - 1, 1'b1, 1'b0});
            if (i != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    exp_q.push_back(5'b00010);
                end
            end
        end
        exp_q.push_back(5'b00001);
    endtask

    task automatic applyStimulus(input int groups, input int gap);
        @(negedge clk);
        check("ready before request", req_ready, 1);
        req_valid  = 1'b1;
        req_groups = CNT_W'(groups);
        req_gap    = GAP_W'(gap);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_groups = CNT_W'($urandom);
        req_gap    = GAP_W'($urandom);
    endtask

    task automatic checkOutput(input string name);
        logic prev_ge;
        obs_ones = 0; obs_len = 0; obs_ends = 0; obs_flags = 0; flag_align_errs = 0;
        prev_ge = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s cycle %0d", name, i), {req_ready, data, grp_end, busy, done}, exp_q[i]);
            obs_ones += int'(data);
            obs_len  += int'(busy);
            obs_ends += int'(grp_end);
            obs_flags += int'(det_flag);
            if (det_flag !== prev_ge) flag_align_errs++;
            prev_ge = grp_end;
        end
    endtask

    task automatic run_burst(input string name, input int groups, input int gap);
        exp_q.delete();
        build_model(groups, gap);
        applyStimulus(groups, gap);
        checkOutput(name);
    endtask

    initial begin
        vecs[0] = '{groups: 1,   gap: 0,  exp_ones: 4,    exp_len: 4,    exp_ends: 1};
        vecs[1] = '{groups: 2,   gap: 2,  exp_ones: 8,    exp_len: 22,   exp_ends: 2};
        vecs[2] = '{groups: 0,   gap: 5,  exp_ones: 0,    exp_len: 0,    exp_ends: 0};
        vecs[3] = '{groups: 3,   gap: 1,  exp_ones: 12,   exp_len: 23,   exp_ends: 3};
        vecs[4] = '{groups: 255, gap: 0,  exp_ones: 1020, exp_len: 1020, exp_ends: 255};
        vecs[5] = '{groups: 1,   gap: 15, exp_ones: 4,    exp_len: 49,   exp_ends: 1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_groups = '0;
        req_gap    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset state", {req_ready, data, grp_end, busy, done}, 5'b10000);

        for (int v = 0; v < 6; v++) begin
            run_burst($sformatf("vec%0d", v), vecs[v].groups, vecs[v].gap);
            check($sformatf("vec%0d ones", v), obs_ones, vecs[v].exp_ones);
            check($sformatf("vec%0d length", v), obs_len, vecs[v].exp_len);
            check($sformatf("vec%0d grp_end count", v), obs_ends, vecs[v].exp_ends);
        end

        for (int r = 0; r < 12; r++) begin
            int g, p;
            g = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 15));
            run_burst($sformatf("rand%0d g%0d p%0d", r, g, p), g, p);
            check($sformatf("rand%0d ones", r), obs_ones, GL * g);
        end

        // Reset on the third one of a three-group burst aborts with no done pulse.
        applyStimulus(3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("pre-reset one %0d", i), data, 1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("after mid-burst reset %0d", i), {req_ready, data, grp_end, busy, done}, 5'b10000);
        end

        // req_valid held high: second burst starts the cycle after done; fields ignored while busy.
        exp_q.delete();
        build_model(1, 1);
        exp_q.push_back(5'b10000);
        build_model(1, 1);
        @(negedge clk);
        req_valid  = 1'b1;
        req_groups = 8'd1;
        req_gap    = 4'd1;
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("held valid cycle %0d", i), {req_ready, data, grp_end, busy, done}, exp_q[i]);
            if (i < 6) begin
                req_groups = CNT_W'($urandom_range(2, 255));
                req_gap    = GAP_W'($urandom_range(2, 15));
            end else if (i == 6) begin
                req_groups = 8'd1;
                req_gap    = 4'd1;
            end else if (i == 9) begin
                req_valid = 1'b0;
            end
        end

        // Detector in the loop: one flag per group, each one cycle after grp_end.
        run_burst("detector loop", 5, 3);
        check("detector flag count", obs_flags, 5);
        check("detector flag alignment errors", flag_align_errs, 0);

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
